inst_buffer: RTL

- Sits directly upstream of the instruction decoder.
- Assembles serial fetch data into 16-bit words, arriving NSHIFT bits per chunk, LSB first.
- Holds the current instruction word and one look-ahead word.
- Serves a rotatable imm16 register: the decoder/scheduler loads it from the look-ahead word, shifts it out NSHIFT bits at a time, and can feed it back (imm8 rotate path).

---
 rtl/inst_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/inst_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : inst_buffer
//  Description : Instruction buffer upstream of the decoder. Assembles serial
//                fetch chunks (LSB first) into 16-bit words, holds the current
//                instruction (IR) plus one look-ahead word (NW), and serves a
//                rotatable imm16 register (IMM) with an imm8 feedback path.
//                Optional macro INST_BUFFER_BYPASS_EN presents a completing
//                word on inst/inst_valid in the same cycle when IR is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_buffer #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSHIFT-1:0]     fetch_data,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic                  flush,
  output logic                  inst_valid,
  output logic [2*REG_BITS-1:0] inst,
  input  logic                  inst_done,
  input  logic                  load_imm16,
  output logic                  imm16_loaded,
  output logic [NSHIFT-1:0]     imm_data,
  input  logic                  next_imm_data,
  input  logic                  feed_imm8,
  input  logic [NSHIFT-1:0]     imm8_data_in,
  output logic [2*REG_BITS-1:0] imm_full
);

  localparam int C_W      = 2 * REG_BITS;
  localparam int C_CHUNKS = C_W / NSHIFT;
  localparam int C_CW     = $clog2(C_CHUNKS);

  logic [C_W-1:0]  r_asm;
  logic [C_CW-1:0] r_cnt;
  logic [C_W-1:0]  r_ir;
  logic            r_ir_full;
  logic [C_W-1:0]  r_nw;
  logic            r_nw_full;
  logic [C_W-1:0]  r_imm;
  logic            r_imm_loaded;

  logic [C_W-1:0]  w_word;
  logic            w_word_done;
  logic            w_bypass;
  logic            w_done;
  logic            w_load;
  logic [1:0]      w_occ;
  logic [C_W-1:0]  w_ir_nxt;
  logic            w_ir_full_nxt;
  logic [C_W-1:0]  w_nw_nxt;
  logic            w_nw_full_nxt;
  logic [NSHIFT-1:0] w_fill;

  // Word completion: the chunk landing on the last count closes the word.
  assign w_word      = {fetch_data, r_asm[C_W-1:NSHIFT]};
  assign w_word_done = fetch_valid && !flush && (r_cnt == C_CW'(C_CHUNKS - 1));

  // Occupancy counts a partially assembled word as a claimed slot.
  assign w_occ       = {1'b0, r_ir_full} + {1'b0, r_nw_full} + {1'b0, (r_cnt != '0)};
  assign fetch_ready = (w_occ < 2'd2);

`ifdef INST_BUFFER_BYPASS_EN
  // IR empty before the edge means it is also empty after consume/load,
  // so the completing word can be shown straight away.
  assign w_bypass = w_word_done && !r_ir_full;
`else
  assign w_bypass = 1'b0;
`endif

  assign inst_valid   = r_ir_full | w_bypass;
  assign inst         = r_ir_full ? r_ir : (w_bypass ? w_word : r_ir);
  assign w_done       = inst_done && inst_valid && !flush;
  assign w_load       = !flush && !w_done && load_imm16 && !r_imm_loaded && r_nw_full;
  assign imm16_loaded = r_imm_loaded;
  assign imm_data     = r_imm[NSHIFT-1:0];
  assign imm_full     = r_imm;
  assign w_fill       = feed_imm8 ? imm8_data_in : r_imm[NSHIFT-1:0];

  // Slot update: consume or imm load first, then place any completed word.
  always_comb begin
    w_ir_nxt      = r_ir;
    w_ir_full_nxt = r_ir_full;
    w_nw_nxt      = r_nw;
    w_nw_full_nxt = r_nw_full;
    if (w_done && r_ir_full) begin
      w_ir_nxt      = r_nw;
      w_ir_full_nxt = r_nw_full;
      w_nw_full_nxt = 1'b0;
    end else if (w_load) begin
      w_nw_full_nxt = 1'b0;
    end
    // A bypassed word consumed in its completion cycle is never stored.
    if (w_word_done && !(w_bypass && w_done)) begin
      if (!w_ir_full_nxt) begin
        w_ir_nxt      = w_word;
        w_ir_full_nxt = 1'b1;
      end else begin
        w_nw_nxt      = w_word;
        w_nw_full_nxt = 1'b1;
      end
    end
  end

  // Assembly, slot and IMM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_asm        <= '0;
      r_cnt        <= '0;
      r_ir         <= '0;
      r_ir_full    <= 1'b0;
      r_nw         <= '0;
      r_nw_full    <= 1'b0;
      r_imm        <= '0;
      r_imm_loaded <= 1'b0;
    end else begin
      if (w_load) begin
        r_imm <= r_nw;
      end else if (next_imm_data) begin
        r_imm <= {w_fill, r_imm[C_W-1:NSHIFT]};
      end
      if (flush) begin
        r_ir_full    <= 1'b0;
        r_nw_full    <= 1'b0;
        r_cnt        <= '0;
        r_imm_loaded <= 1'b0;
      end else begin
        if (fetch_valid) begin
          r_asm <= w_word;
          r_cnt <= r_cnt + C_CW'(1);
        end
        r_ir      <= w_ir_nxt;
        r_ir_full <= w_ir_full_nxt;
        r_nw      <= w_nw_nxt;
        r_nw_full <= w_nw_full_nxt;
        if (w_done) begin
          r_imm_loaded <= 1'b0;
        end else if (w_load) begin
          r_imm_loaded <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
